alu_mul_sequencer: RTL and testbench

Multi-cycle command sequencer that drives the shared 64-bit ALU (AND/OR/ADD/SUB/NOR/SLLI op encoding) to perform iterative MUL (shift-add) and SLL (repeated doubling), plus single-cycle pass-through ALU ops. It sits between the execute-stage issue logic and the ALU. Requests and results use a valid/ready handshake. Only the ALU's ADD encoding is used for iterative work.

---
 rtl/alu_mul_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Drives a shared single-cycle ALU to perform shift-add MUL, SLL by repeated
// doubling and single pass-through ALU ops, with valid/ready on both sides.
module alu_mul_sequencer #(
  parameter int          WIDTH   = 64,
  parameter logic [3:0]  ALU_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_cmd,
  input  logic [3:0]       req_aluop,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] CMD_MUL    = 2'b00;
  localparam logic [1:0] CMD_SLL    = 2'b01;
  localparam logic [1:0] CMD_SINGLE = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, mcand_reg, mplier_reg;
  logic [CW-1:0]    count_reg;
  logic [1:0]       cmd_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] resp_result_reg;
  logic             resp_zero_reg, resp_err_reg;

  logic             accept, finish, load_resp, err_next;
  logic [CW-1:0]    n_init;
  logic [WIDTH-1:0] result_next;

  // Iteration count for the incoming command.
  always_comb begin
    n_init = '0;
    case (req_cmd)
      CMD_MUL: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (req_b[i]) n_init = CW'(i + 1);
        end
      end
      CMD_SLL:    n_init = CW'(req_b[SW-1:0]);
      CMD_SINGLE: n_init = CW'(1);
      default:    n_init = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_ADD;
    accept      = 1'b0;
    finish      = 1'b0;
    load_resp   = 1'b0;
    result_next = '0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (n_init == '0) begin
            // Zero-length commands respond straight away; SLL by 0 returns A.
            state_next  = DONE;
            load_resp   = 1'b1;
            result_next = (req_cmd == CMD_SLL) ? req_a : '0;
            err_next    = (req_cmd == CMD_RSVD);
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        case (cmd_reg)
          CMD_MUL: begin
            alu_a       = acc_reg;
            alu_b       = mcand_reg;
            finish      = ((mplier_reg >> 1) == '0);
            result_next = mplier_reg[0] ? alu_result : acc_reg;
          end
          CMD_SLL: begin
            alu_a       = acc_reg;
            alu_b       = acc_reg;
            finish      = (count_reg == CW'(1));
            result_next = alu_result;
          end
          CMD_SINGLE: begin
            alu_a       = acc_reg;
            alu_b       = mcand_reg;
            alu_op      = op_reg;
            finish      = 1'b1;
            result_next = alu_result;
          end
          default: begin
            finish = 1'b1;
          end
        endcase
        if (finish) begin
          state_next = DONE;
          load_resp  = 1'b1;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: SINGLE reuses acc/mcand to hold its latched A/B operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg         <= '0;
      mcand_reg       <= '0;
      mplier_reg      <= '0;
      count_reg       <= '0;
      cmd_reg         <= CMD_MUL;
      op_reg          <= ALU_ADD;
      resp_result_reg <= '0;
      resp_zero_reg   <= 1'b0;
      resp_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        cmd_reg   <= req_cmd;
        op_reg    <= req_aluop;
        count_reg <= n_init;
        case (req_cmd)
          CMD_MUL: begin
            acc_reg    <= '0;
            mcand_reg  <= req_a;
            mplier_reg <= req_b;
          end
          CMD_SLL: begin
            acc_reg    <= req_a;
            mcand_reg  <= '0;
            mplier_reg <= '0;
          end
          CMD_SINGLE: begin
            acc_reg    <= req_a;
            mcand_reg  <= req_b;
            mplier_reg <= '0;
          end
          default: begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
          end
        endcase
      end else if (busy) begin
        case (cmd_reg)
          CMD_MUL: begin
            if (mplier_reg[0]) acc_reg <= alu_result;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
          end
          CMD_SLL: begin
            acc_reg   <= alu_result;
            count_reg <= count_reg - CW'(1);
          end
          default: begin
            count_reg <= '0;
          end
        endcase
      end
      if (load_resp) begin
        resp_result_reg <= result_next;
        resp_zero_reg   <= (result_next == '0);
        resp_err_reg    <= err_next;
      end
    end
  end

  assign resp_result = resp_result_reg;
  assign resp_zero   = resp_zero_reg;
  assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer: a behavioural ALU plus a
// transaction-level model of results, latency and handshake phases.
module tb_alu_mul_sequencer;
  localparam int         W   = 64;
  localparam logic [3:0] ADD = 4'b0010;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [1:0]   req_cmd;
  logic [3:0]   req_aluop;
  logic [W-1:0] req_a, req_b;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_op;
  logic         resp_valid, resp_ready;
  logic [W-1:0] resp_result;
  logic         resp_zero, resp_err, busy;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1100: return ~(a | b);
      4'b0011: return a << b[5:0];
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  alu_mul_sequencer #(.WIDTH(W), .ALU_ADD(ADD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_aluop(req_aluop), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  bit chk_en = 0;

  task automatic check64(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int n_of(logic [1:0] cmd, logic [W-1:0] b);
    int n = 0;
    case (cmd)
      2'b00: for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      2'b01: n = int'(b[5:0]);
      2'b10: n = 1;
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic logic [W-1:0] expect_of(logic [1:0] cmd, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (cmd)
      2'b00: return a * b;
      2'b01: return a << b[5:0];
      2'b10: return alu_fn(a, b, op);
      default: return '0;
    endcase
  endfunction

  // Model: phase 0 idle, 1 busy (m_left cycles to go), 2 done.
  int           m_phase, m_left, m_n;
  logic [1:0]   m_cmd;
  logic [3:0]   m_op;
  logic [W-1:0] m_a, m_b, m_result;
  logic         m_err;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_left = 0; m_result = '0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_cmd = req_cmd; m_op = req_aluop; m_a = req_a; m_b = req_b;
          m_n = n_of(req_cmd, req_b);
          m_result = expect_of(req_cmd, req_aluop, req_a, req_b);
          m_err = (req_cmd == 2'b11);
          m_left = m_n;
          m_phase = (m_n == 0) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check64("req_ready", W'(req_ready), W'(m_phase == 0));
      check64("busy", W'(busy), W'(m_phase == 1));
      check64("resp_valid", W'(resp_valid), W'(m_phase == 2));
      if (m_phase == 2) begin
        check64("resp_result", resp_result, m_result);
        check64("resp_zero", W'(resp_zero), W'(m_result == '0));
        check64("resp_err", W'(resp_err), W'(m_err));
      end
      if (m_phase == 1) begin
        check64("alu_op", W'(alu_op), W'((m_cmd == 2'b10) ? m_op : ADD));
        if (m_cmd == 2'b01) check64("sll_alu_a_eq_b", alu_a, alu_b);
        if (m_cmd == 2'b10) begin
          check64("single_alu_a", alu_a, m_a);
          check64("single_alu_b", alu_b, m_b);
        end
      end else begin
        check64("idle_alu_a", alu_a, '0);
        check64("idle_alu_b", alu_b, '0);
        check64("idle_alu_op", W'(alu_op), W'(ADD));
      end
    end
  end

  task automatic issue(logic [1:0] cmd, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int k = 0;
    @(posedge clk); #1;
    req_cmd = cmd; req_aluop = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    t0 = cyc;
    req_valid = 1'b0;
    $display("cmd=%0d op=%h a=%h b=%h accepted at cycle %0d", cmd, op, a, b, t0);
  endtask

  task automatic wait_resp(input int stall, output logic [W-1:0] r, output logic z, output logic e,
                           output logic [W-1:0] mr, output int lat, output int mn);
    int k = 0;
    @(negedge clk);
    while (!resp_valid && k < 300) begin @(negedge clk); k++; end
    if (!resp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got resp_valid=0 expected 1 within 300 cycles");
    end
    lat = cyc - t0; r = resp_result; z = resp_zero; e = resp_err; mr = m_result; mn = m_n;
    repeat (stall) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic expect_resp(string name, logic [W-1:0] er, logic ez, logic ee, int elat);
    logic [W-1:0] r, mr;
    logic z, e;
    int lat, mn;
    wait_resp(0, r, z, e, mr, lat, mn);
    $display("%s: result=%h zero=%0b err=%0b latency=%0d", name, r, z, e, lat);
    check64({name, "_result"}, r, er);
    check64({name, "_zero"}, W'(z), W'(ez));
    check64({name, "_err"}, W'(e), W'(ee));
    check64({name, "_latency"}, W'(lat), W'(elat));
    check64({name, "_model"}, mr, er);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return W'($urandom_range(0, 255));
      2: return W'(1) << $urandom_range(0, 63);
      default: return '1;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   ops [6];
    logic [W-1:0] r, mr;
    logic         z, e;
    int           lat, mn;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0011};

    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_aluop = '0;
    req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check64("rst_resp_valid", W'(resp_valid), '0);
    check64("rst_resp_result", resp_result, '0);
    check64("rst_resp_zero", W'(resp_zero), '0);
    check64("rst_resp_err", W'(resp_err), '0);
    check64("rst_busy", W'(busy), '0);
    check64("rst_req_ready", W'(req_ready), W'(1));
    reset = 1'b0;
    chk_en = 1'b1;

    issue(2'b00, 4'h0, 64'd7, 64'd6);
    expect_resp("mul_7x6", 64'd42, 1'b0, 1'b0, 3);
    issue(2'b00, 4'h0, 64'd5, 64'd0);
    expect_resp("mul_b0", 64'd0, 1'b1, 1'b0, 0);
    issue(2'b00, 4'h0, 64'h8000_0000_0000_0000, 64'd2);
    expect_resp("mul_ovf", 64'd0, 1'b1, 1'b0, 2);
    issue(2'b01, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FF05);
    expect_resp("sll_5", 64'd32, 1'b0, 1'b0, 5);
    issue(2'b10, 4'b0110, 64'd10, 64'd10);
    expect_resp("single_sub", 64'd0, 1'b1, 1'b0, 1);
    issue(2'b11, 4'h0, 64'd5, 64'd9);
    expect_resp("reserved", 64'd0, 1'b1, 1'b1, 0);

    // Stall in DONE with a new command pending.
    issue(2'b00, 4'h0, 64'd7, 64'd6);
    begin
      int k = 0;
      @(negedge clk);
      while (!resp_valid && k < 300) begin @(negedge clk); k++; end
    end
    req_cmd = 2'b01; req_aluop = 4'h0; req_a = 64'd3; req_b = 64'd2; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check64("stall_result", resp_result, 64'd42);
      check64("stall_req_ready", W'(req_ready), '0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check64("no_b2b_req_ready", W'(req_ready), W'(1));
    check64("no_b2b_busy", W'(busy), '0);
    @(posedge clk); #1;
    t0 = cyc;
    req_valid = 1'b0;
    expect_resp("held_sll", 64'd12, 1'b0, 1'b0, 2);

    // Asynchronous reset in the middle of a long MUL.
    issue(2'b00, 4'h0, 64'd3, 64'h0000_0100_0000_0000);
    repeat (5) @(negedge clk);
    check64("pre_reset_busy", W'(busy), W'(1));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check64("arst_busy", W'(busy), '0);
    check64("arst_req_ready", W'(req_ready), W'(1));
    check64("arst_resp_valid", W'(resp_valid), '0);
    check64("arst_alu_a", alu_a, '0);
    check64("arst_resp_result", resp_result, '0);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 4'h0, 64'd3, 64'd4);
    expect_resp("mul_after_rst", 64'd12, 1'b0, 1'b0, 3);

    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [1:0] cmd;
      sel = $urandom_range(0, 9);
      cmd = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      issue(cmd, ops[$urandom_range(0, 5)], rand_operand(), rand_operand());
      wait_resp($urandom_range(0, 3), r, z, e, mr, lat, mn);
      $display("rand %0d: result=%h expected=%h latency=%0d", n, r, mr, lat);
      check64("rand_latency", W'(lat), W'(mn));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
